// File: rtl/io_bus_master_if.sv
// Request/response handshakes and bus address/strobe of io_bus_master.
// master: the io_bus_master side. slave: the core plus peripheral side.
// The shared data net is a resolved tristate, so it stays a plain inout port
// on the block instead of living in this interface.
interface io_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] bus_addr;
  logic        bus_we;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_we
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_we
  );
endinterface

// File: rtl/io_bus_master.sv
// io_bus_master: turns single core load/store requests into bus cycles on the
// peripheral bus and returns one response per request.
// Ports:
//   clk       system clock, all state on posedge
//   rst       synchronous active-high reset
//   bus       io_bus_master_if.master: req_* handshake in, rsp_* handshake out,
//             bus_addr / bus_we to the peripheral register file
//   bus_data  shared 32-bit data, driven here only while bus_we=1
module io_bus_master #(
  parameter int unsigned ADDR_MAX  = 60,
  parameter int unsigned READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  io_bus_master_if.master   bus,
  inout  wire  [31:0]       bus_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          req_ready_c;
  logic          accept_c;
  logic          bad_addr_c;
  logic          drive_c;

  // Handshake decode; reset blocks acceptance even while the state reads IDLE.
  assign req_ready_c = (state_q == S_IDLE) && !rst;
  assign accept_c    = bus.req_valid && req_ready_c;
  assign bad_addr_c  = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr > DW'(ADDR_MAX));

  // Write strobe and data drive come straight from the state, gated by reset
  // so an interrupted WRITE never reaches the responder.
  assign drive_c = (state_q == S_WRITE) && !rst;

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = '0;
          if (bad_addr_c) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (bus.req_we) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        state_d = S_RESP;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      S_READ: begin
        // Address has been held READ_WAIT extra cycles; sample the responder.
        if (cnt_q == CW'(READ_WAIT)) begin
          state_d = S_RESP;
          rdata_d = bus_data;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from registered state.
  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.bus_addr  = ((state_q == S_WRITE) || (state_q == S_READ)) ? addr_q : '0;
  assign bus.bus_we    = drive_c;
  assign bus_data      = drive_c ? wdata_q : 'z;

endmodule

// File: tb/tb_io_bus_master.sv
// Self-checking bench for io_bus_master: a vector table of single requests,
// hand-written reset-interruption sequences and a random request stream
// checked against a register-file scoreboard.
module tb_io_bus_master;

  localparam int RW  = 1;
  localparam int RW3 = 3;
  localparam int TMO = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst3;

  io_bus_master_if bif ();
  io_bus_master_if bif3 ();

  wire [31:0] bus_data;
  wire [31:0] bus_data3;

  io_bus_master #(.ADDR_MAX(60), .READ_WAIT(RW)) u_dut (
    .clk(clk), .rst(rst), .bus(bif), .bus_data(bus_data)
  );

  io_bus_master #(.ADDR_MAX(60), .READ_WAIT(RW3)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(bif3), .bus_data(bus_data3)
  );

  int errors = 0;
  int checks = 0;

  // Peripheral responder: register words plus read-only inputs at 12/20/56/60.
  logic [31:0] regs [16] = '{default: 32'h0};
  logic [31:0] sw, gpio56, gpio60;
  logic [1:0]  btn;
  logic [31:0] resp_val;
  logic [31:0] last_wa, last_wd;
  int          wr_count = 0;
  int          act_cycles = 0;
  int          wr3_count = 0;

  always_comb begin
    case (bif.bus_addr)
      32'd12:  resp_val = sw;
      32'd20:  resp_val = {30'b0, btn};
      32'd56:  resp_val = gpio56;
      32'd60:  resp_val = gpio60;
      default: resp_val = regs[bif.bus_addr[5:2]];
    endcase
  end

  assign bus_data  = bif.bus_we  ? 'z : resp_val;
  assign bus_data3 = bif3.bus_we ? 'z : 32'h0000_A5A5;

  always @(posedge clk) begin
    if (bif.bus_we) begin
      regs[bif.bus_addr[5:2]] <= bus_data;
      last_wa  <= bif.bus_addr;
      last_wd  <= bus_data;
      wr_count <= wr_count + 1;
    end
    if (bif.bus_we || (bif.bus_addr != 32'd0)) act_cycles <= act_cycles + 1;
    if (bif3.bus_we) wr3_count <= wr3_count + 1;
  end

  // Reference model: memory words written by stores, inputs override reads.
  logic [31:0] mem [16] = '{default: 32'h0};

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a == 32'd12) return sw;
    if (a == 32'd20) return {30'b0, btn};
    if (a == 32'd56) return gpio56;
    if (a == 32'd60) return gpio60;
    return mem[a[5:2]];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // One request on the main DUT; request inputs are scrambled (and req_valid
  // kept high) after acceptance to show nothing is re-sampled outside IDLE.
  task automatic do_txn(input string nm, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input logic exp_err,
                        input logic [31:0] exp_rdata, input int exp_lat);
    int w;
    int k;
    int act0;
    int wr0;
    int exp_act;
    exp_act = exp_err ? 0 : (we ? 1 : ((addr == 32'd0) ? 0 : RW + 1));
    @(negedge clk);
    bif.req_valid = 1'b1;
    bif.req_we    = we;
    bif.req_addr  = addr;
    bif.req_wdata = wdata;
    w = 0;
    while (!bif.req_ready && w < TMO) begin
      @(negedge clk);
      w++;
    end
    check({nm, " accept_wait"}, 32'(w), 32'd0);
    act0 = act_cycles;
    wr0  = wr_count;
    @(posedge clk); #1;
    bif.req_we    = 1'($urandom);
    bif.req_addr  = $urandom;
    bif.req_wdata = $urandom;
    k = 0;
    while (!bif.rsp_valid && k < TMO) begin
      @(posedge clk); #1;
      k++;
    end
    bif.req_valid = 1'b0;
    check({nm, " latency"}, 32'(k), 32'(exp_lat));
    for (int i = 0; i <= hold; i++) begin
      check1({nm, " rsp_valid"}, bif.rsp_valid, 1'b1);
      check1({nm, " rsp_err"}, bif.rsp_err, exp_err);
      check({nm, " rsp_rdata"}, bif.rsp_rdata, exp_rdata);
      check1({nm, " req_ready_busy"}, bif.req_ready, 1'b0);
      if (i < hold) begin
        @(posedge clk); #1;
      end
    end
    bif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bif.rsp_ready = 1'b0;
    check1({nm, " rsp_done"}, bif.rsp_valid, 1'b0);
    check1({nm, " req_ready_after"}, bif.req_ready, 1'b1);
    check({nm, " bus_cycles"}, 32'(act_cycles - act0), 32'(exp_act));
    check({nm, " writes"}, 32'(wr_count - wr0), (we && !exp_err) ? 32'd1 : 32'd0);
    if (we && !exp_err) begin
      check({nm, " wr_addr"}, last_wa, addr);
      check({nm, " wr_data"}, last_wd, wdata);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int k;
    int wr0;
    int seen;
    logic        rwe;
    logic [31:0] ra, rd, rexp;

    tbl[0]  = '{1'b1, 32'd4,          32'h0000_03FF, 0, 1'b0, 32'h0,          1};
    tbl[1]  = '{1'b0, 32'd4,          32'h0,         0, 1'b0, 32'h0000_03FF,  1 + RW};
    tbl[2]  = '{1'b0, 32'd12,         32'h0,         0, 1'b0, 32'h0000_0155,  1 + RW};
    tbl[3]  = '{1'b0, 32'h6,          32'h0,         0, 1'b1, 32'h0,          0};
    tbl[4]  = '{1'b1, 32'd64,         32'h1111_2222, 0, 1'b1, 32'h0,          0};
    tbl[5]  = '{1'b0, 32'd20,         32'h0,         3, 1'b0, 32'h0000_0002,  1 + RW};
    tbl[6]  = '{1'b1, 32'd60,         32'hDEAD_BEEF, 1, 1'b0, 32'h0,          1};
    tbl[7]  = '{1'b0, 32'd60,         32'h0,         0, 1'b0, 32'h0000_F00D,  1 + RW};
    tbl[8]  = '{1'b1, 32'hFFFF_FFFC,  32'h5555_AAAA, 0, 1'b1, 32'h0,          0};
    tbl[9]  = '{1'b0, 32'd61,         32'h0,         0, 1'b1, 32'h0,          0};
    tbl[10] = '{1'b1, 32'd0,          32'h1234_5678, 0, 1'b0, 32'h0,          1};
    tbl[11] = '{1'b0, 32'd0,          32'h0,         0, 1'b0, 32'h1234_5678,  1 + RW};
    tbl[12] = '{1'b0, 32'd56,         32'h0,         2, 1'b0, 32'h0BAD_CAFE,  1 + RW};

    sw = 32'h0000_0155; btn = 2'b10; gpio56 = 32'h0BAD_CAFE; gpio60 = 32'h0000_F00D;
    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;
    bif.rsp_ready = 1'b0;
    bif3.req_valid = 1'b0; bif3.req_we = 1'b0; bif3.req_addr = '0; bif3.req_wdata = '0;
    bif3.rsp_ready = 1'b0;
    rst = 1'b1; rst3 = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check1("rst req_ready", bif.req_ready, 1'b0);
    check1("rst rsp_valid", bif.rsp_valid, 1'b0);
    check1("rst rsp_err", bif.rsp_err, 1'b0);
    check("rst rsp_rdata", bif.rsp_rdata, 32'h0);
    check1("rst bus_we", bif.bus_we, 1'b0);
    check("rst bus_addr", bif.bus_addr, 32'h0);
    rst = 1'b0; rst3 = 1'b0;
    #1;
    check1("post-rst req_ready", bif.req_ready, 1'b1);
    check1("post-rst req_ready3", bif3.req_ready, 1'b1);

    // rsp_ready while idle does nothing.
    @(negedge clk); bif.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check1("idle rsp_ready rsp_valid", bif.rsp_valid, 1'b0);
    check1("idle rsp_ready req_ready", bif.req_ready, 1'b1);
    bif.rsp_ready = 1'b0;

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      do_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
             tbl[i].err, tbl[i].rdata, tbl[i].lat);
      if (tbl[i].we && !tbl[i].err) mem[tbl[i].addr[5:2]] = tbl[i].wdata;
    end

    // Reset during the WRITE cycle: the store must not land.
    wr0 = wr_count;
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_addr = 32'd8; bif.req_wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    check1("wrst in_write bus_we", bif.bus_we, 1'b1);
    rst = 1'b1;
    #1;
    check1("wrst gated bus_we", bif.bus_we, 1'b0);
    @(posedge clk); #1;
    check1("wrst rsp_valid", bif.rsp_valid, 1'b0);
    check("wrst bus_addr", bif.bus_addr, 32'h0);
    check1("wrst req_ready_in_rst", bif.req_ready, 1'b0);
    rst = 1'b0;
    #1;
    check1("wrst req_ready", bif.req_ready, 1'b1);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bif.rsp_valid) seen++;
    end
    check("wrst no_rsp", 32'(seen), 32'd0);
    check("wrst no_write", 32'(wr_count - wr0), 32'd0);
    do_txn("wrst readback", 1'b0, 32'd8, 32'h0, 0, 1'b0, model_read(32'd8), 1 + RW);

    // Reset during READ with wait counter at 1 (READ_WAIT=3 instance).
    @(negedge clk);
    bif3.req_valid = 1'b1; bif3.req_we = 1'b0; bif3.req_addr = 32'd16;
    @(posedge clk); #1;
    bif3.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rrst bus_addr_reading", bif3.bus_addr, 32'd16);
    rst3 = 1'b1;
    @(posedge clk); #1;
    check1("rrst rsp_valid", bif3.rsp_valid, 1'b0);
    check("rrst bus_addr", bif3.bus_addr, 32'h0);
    check1("rrst bus_we", bif3.bus_we, 1'b0);
    check("rrst rsp_rdata", bif3.rsp_rdata, 32'h0);
    rst3 = 1'b0;
    #1;
    check1("rrst req_ready", bif3.req_ready, 1'b1);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bif3.rsp_valid) seen++;
    end
    check("rrst no_rsp", 32'(seen), 32'd0);

    // Full load on the READ_WAIT=3 instance for its latency.
    @(negedge clk);
    bif3.req_valid = 1'b1; bif3.req_addr = 32'd16;
    @(posedge clk); #1;
    bif3.req_valid = 1'b0;
    k = 0;
    while (!bif3.rsp_valid && k < TMO) begin
      @(posedge clk); #1;
      k++;
    end
    check("rw3 latency", 32'(k), 32'(1 + RW3));
    check("rw3 rdata", bif3.rsp_rdata, 32'h0000_A5A5);
    bif3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bif3.rsp_ready = 1'b0;
    check1("rw3 done", bif3.rsp_valid, 1'b0);
    check("rw3 no_writes", 32'(wr3_count), 32'd0);

    // Random back-to-back aligned traffic against the scoreboard.
    for (int i = 0; i < 20; i++) begin
      sw     = $urandom;
      btn    = 2'($urandom);
      gpio56 = $urandom;
      gpio60 = $urandom;
      ra  = 32'(4 * $urandom_range(0, 15));
      rwe = 1'($urandom);
      rd  = $urandom;
      rexp = rwe ? 32'h0 : model_read(ra);
      do_txn($sformatf("rnd%0d", i), rwe, ra, rd, $urandom_range(0, 2), 1'b0, rexp,
             rwe ? 1 : 1 + RW);
      if (rwe) mem[ra[5:2]] = rd;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
